// File: rtl/collision_scanner.sv
// Collision scanner: walks bullet slots 0..7 on start, pulses isCollide per overlapping live bullet, tracks saturating HP.
// Latency: 1 cycle per slot without a hit, 2 with a hit; done arrives 9..17 cycles after start.
// Backpressure: none; start while busy is ignored. Define COLLIDE_HEAL_EN to make green bullets heal.
module collision_scanner #(
    parameter int HP_MAX     = 100,
    parameter int DMG_WHITE  = 5,
    parameter int DMG_BLUE   = 10,
    parameter int HEAL_GREEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] player_pos,
    input  logic [15:0] player_size,
    output logic [2:0]  index2,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [1:0]  color2,
    input  logic        isRender2,
    output logic        isCollide,
    output logic [7:0]  hp,
    output logic        dead,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HIT, ST_DONE} state_t;

    localparam logic [8:0] HP_MAX9 = 9'(HP_MAX);
    localparam logic [8:0] DMG_W9  = 9'(DMG_WHITE);
    localparam logic [8:0] DMG_B9  = 9'(DMG_BLUE);
    localparam logic [8:0] HEAL9   = 9'(HEAL_GREEN);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [1:0]  col_q;
    logic        coll_q;
    logic [7:0]  hp_q;
    logic [7:0]  hp_d;
    logic        dead_q;
    logic        busy_q;
    logic        done_q;

    logic [8:0]  px, py, pw, ph, bx, by, bw, bh;
    logic        hit_c;
    logic        is_heal;
    logic [8:0]  cur_hp, dmg, heal_sum;

    assign px = {1'b0, player_pos[15:8]};
    assign py = {1'b0, player_pos[7:0]};
    assign pw = {1'b0, player_size[15:8]};
    assign ph = {1'b0, player_size[7:0]};
    assign bx = {1'b0, position2[15:8]};
    assign by = {1'b0, position2[7:0]};
    assign bw = {1'b0, size2[15:8]};
    assign bh = {1'b0, size2[7:0]};

    // Strict inequalities on 9-bit sums: touching edges do not collide, no wrap at 255.
    assign hit_c = isRender2 && (color2 != 2'd3)
                && (pw != 9'd0) && (ph != 9'd0) && (bw != 9'd0) && (bh != 9'd0)
                && (px < bx + bw) && (bx < px + pw)
                && (py < by + bh) && (by < py + ph);

`ifdef COLLIDE_HEAL_EN
    assign is_heal = (col_q == 2'd1);
`else
    assign is_heal = 1'b0;
`endif

    assign cur_hp   = {1'b0, hp_q};
    assign dmg      = (col_q == 2'd2) ? DMG_B9 : DMG_W9;
    assign heal_sum = cur_hp + HEAL9;

    always_comb begin
        hp_d = hp_q;
        if (!dead_q) begin
            if (is_heal) begin
                hp_d = (heal_sum > HP_MAX9) ? HP_MAX9[7:0] : heal_sum[7:0];
            end else begin
                hp_d = (cur_hp <= dmg) ? 8'd0 : 8'(cur_hp - dmg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            col_q   <= 2'd0;
            coll_q  <= 1'b0;
            hp_q    <= HP_MAX9[7:0];
            dead_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SCAN;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (hit_c) begin
                        state_q <= ST_HIT;
                        coll_q  <= 1'b1;
                        col_q   <= color2;
                    end else if (idx_q == 3'd7) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_HIT: begin
                    coll_q <= 1'b0;
                    hp_q   <= hp_d;
                    dead_q <= (hp_d == 8'd0);
                    if (idx_q == 3'd7) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SCAN;
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign index2    = idx_q;
    assign isCollide = coll_q;
    assign hp        = hp_q;
    assign dead      = dead_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a behavioural 8-slot bullet table on the secondary port.
module tb_collision_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic [2:0]  index2;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [1:0]  color2;
    logic        isRender2;
    logic        isCollide;
    logic [7:0]  hp;
    logic        dead;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    collision_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .player_pos  (player_pos),
        .player_size (player_size),
        .index2      (index2),
        .position2   (position2),
        .size2       (size2),
        .color2      (color2),
        .isRender2   (isRender2),
        .isCollide   (isCollide),
        .hp          (hp),
        .dead        (dead),
        .busy        (busy),
        .done        (done)
    );

    logic [7:0] tx [8];
    logic [7:0] ty [8];
    logic [7:0] tw [8];
    logic [7:0] th [8];
    logic [1:0] tc [8];
    logic       tl [8];

    always_comb begin
        position2 = {tx[index2], ty[index2]};
        size2     = {tw[index2], th[index2]};
        color2    = tc[index2];
        isRender2 = tl[index2];
    end

    // Table clears the addressed slot's render bit on the edge that ends the collide pulse.
    always @(posedge clk) begin
        if (isCollide) tl[index2] = 1'b0;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                            input int c, input int l);
        tx[i] = 8'(x); ty[i] = 8'(y); tw[i] = 8'(w); th[i] = 8'(h);
        tc[i] = 2'(c); tl[i] = 1'(l);
    endtask

    task automatic set_far();
        for (int i = 0; i < 8; i++) set_slot(i, 200, 200, 4, 4, 0, 1);
    endtask

    task automatic set_player(input int x, input int y, input int w, input int h);
        player_pos  = {8'(x), 8'(y)};
        player_size = {8'(w), 8'(h)};
    endtask

    // Cycle k is the value the edge N+k samples, observed at the preceding negedge.
    task automatic run_scan(input int poke_k, input int rst_k,
                            output int done_k, output int nhit, output int last_idx);
        done_k   = 0;
        nhit     = 0;
        last_idx = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == poke_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                break;
            end
            if (isCollide) begin
                nhit++;
                last_idx = int'(index2);
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int dk, nh, li, cnt;
    int exp_hp [4];
    int exp_dead [4];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_player(0, 0, 4, 4);
        set_far();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hp", hp, 100);
        check("rst_dead", dead, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coll", isCollide, 0);
        check("rst_idx", index2, 0);

        // No overlap: all slots live far to the right
        set_player(0, 0, 4, 4);
        for (int i = 0; i < 8; i++) set_slot(i, 100 + 8 * i, 0, 4, 4, 0, 1);
        run_scan(0, 0, dk, nh, li);
        check("nohit_done", dk, 9);
        check("nohit_coll", nh, 0);
        check("nohit_hp", hp, 100);

        // Single blue hit in slot 2
        set_far();
        set_player(20, 20, 8, 8);
        set_slot(2, 16, 16, 8, 8, 2, 1);
        run_scan(0, 0, dk, nh, li);
        check("blue_done", dk, 10);
        check("blue_coll", nh, 1);
        check("blue_idx", li, 2);
        check("blue_hp", hp, 90);
        check("blue_dead", dead, 0);

        // Edge touch, dead slot, zero width, inert colour
        set_far();
        set_player(15, 10, 5, 5);
        set_slot(0, 10, 10, 5, 5, 0, 1);
        set_slot(1, 14, 10, 5, 5, 0, 0);
        set_slot(3, 14, 10, 0, 5, 0, 1);
        set_slot(4, 15, 15, 5, 5, 0, 1);
        set_slot(5, 14, 10, 5, 5, 3, 1);
        run_scan(0, 0, dk, nh, li);
        check("edge_done", dk, 9);
        check("edge_coll", nh, 0);
        check("edge_hp", hp, 90);

        // Sums past 255 must not wrap
        set_far();
        set_player(250, 250, 10, 10);
        set_slot(6, 252, 252, 8, 8, 0, 1);
        run_scan(0, 0, dk, nh, li);
        check("wrap_coll", nh, 1);
        check("wrap_idx", li, 6);
        check("wrap_hp", hp, 85);

        // start pulsed mid-scan is ignored and does not restart
        set_far();
        set_player(20, 20, 8, 8);
        set_slot(4, 22, 22, 4, 4, 0, 1);
        run_scan(3, 0, dk, nh, li);
        check("poke_done", dk, 10);
        check("poke_coll", nh, 1);
        check("poke_idx", li, 4);
        check("poke_hp", hp, 80);
        repeat (4) @(negedge clk);
        check("poke_idle", busy, 0);

        // Saturation to zero over three full-hit scans, fourth still clears bullets
        do_reset();
        @(negedge clk);
        check("rst2_hp", hp, 100);
        exp_hp   = '{60, 20, 0, 0};
        exp_dead = '{0, 0, 1, 1};
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 8; i++) set_slot(i, 22, 22, 4, 4, 0, 1);
            run_scan(0, 0, dk, nh, li);
            check($sformatf("sat%0d_done", s), dk, 17);
            check($sformatf("sat%0d_coll", s), nh, 8);
            check($sformatf("sat%0d_hp", s), hp, exp_hp[s]);
            check($sformatf("sat%0d_dead", s), dead, exp_dead[s]);
        end
        check("sat_last_idx", li, 7);

        // Reset at scan cycle 5 aborts with no done
        for (int i = 0; i < 8; i++) set_slot(i, 22, 22, 4, 4, 0, 1);
        run_scan(0, 5, dk, nh, li);
        #1;
        check("abort_idx", index2, 0);
        check("abort_coll", isCollide, 0);
        check("abort_hp", hp, 100);
        check("abort_dead", dead, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // Green: heals with the macro, damages as white without it
        set_far();
        set_player(20, 20, 8, 8);
        set_slot(0, 22, 22, 4, 4, 0, 1);
        set_slot(1, 22, 22, 4, 4, 1, 1);
        run_scan(0, 0, dk, nh, li);
        check("green1_coll", nh, 2);
`ifdef COLLIDE_HEAL_EN
        check("green1_hp", hp, 98);
`else
        check("green1_hp", hp, 90);
`endif
        set_far();
        set_slot(1, 22, 22, 4, 4, 1, 1);
        run_scan(0, 0, dk, nh, li);
        check("green2_done", dk, 10);
`ifdef COLLIDE_HEAL_EN
        check("green2_hp", hp, 100);
`else
        check("green2_hp", hp, 85);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
